// File: rtl/level_meter_if.sv
// ----------------------------------------------------------------------------
// level_meter_if
//
// Bundles the audio sample bus and the meter status/display signals that
// connect the mixer output stage to level_meter.
//
// Signals:
//   sample_valid  single-cycle strobe, audio_bus valid in this cycle
//   audio_bus     NUM_CH x 24-bit signed samples, channel 0 in the low bits
//   sel           channel shown on led / clip_led
//   led           8-segment thermometer bargraph of the selected peak
//   clip_led      clip indicator of the selected channel
//   busy          channel sweep in progress
//   overrun       sticky, a strobe arrived while busy
//   update_done   one-cycle pulse when a sweep completes
//
// Modports:
//   master  the sample source / front panel (drives strobe, bus, sel)
//   slave   the level_meter itself
// ----------------------------------------------------------------------------
interface level_meter_if #(
    parameter int NUM_CH = 8
);
    logic                   sample_valid;
    logic [24*NUM_CH-1:0]   audio_bus;
    logic [2:0]             sel;
    logic [7:0]             led;
    logic                   clip_led;
    logic                   busy;
    logic                   overrun;
    logic                   update_done;

    modport master (
        output sample_valid,
        output audio_bus,
        output sel,
        input  led,
        input  clip_led,
        input  busy,
        input  overrun,
        input  update_done
    );

    modport slave (
        input  sample_valid,
        input  audio_bus,
        input  sel,
        output led,
        output clip_led,
        output busy,
        output overrun,
        output update_done
    );
endinterface

// File: rtl/level_meter.sv
// ----------------------------------------------------------------------------
// level_meter
//
// Per-channel peak level meter for the eight-channel mixer output. On each
// sample strobe the whole audio bus is captured into a shadow register and
// then swept one channel per cycle, updating a peak-hold/decay envelope (and
// optionally a clip hold counter) for every channel. One channel, chosen by
// sel, is shown on an 8-segment bargraph and a clip indicator.
//
// Ports:
//   clk     DSP clock
//   rst_n   asynchronous active-low reset
//   bus     level_meter_if.slave
//             in : sample_valid, audio_bus[24*NUM_CH], sel[3]
//             out: led[8], clip_led, busy, overrun, update_done
//
// Parameters:
//   NUM_CH        number of channels on the audio bus
//   HOLD_SAMPLES  samples a new peak is held before decay starts
//   DECAY_SHIFT   decay step per sample is peak >> DECAY_SHIFT (minimum 1)
//   CLIP_HOLD     samples the clip indicator stays lit after the last clip
//
// Build option:
//   LEVEL_METER_CLIP_EN  when defined, builds clip detection and the per-
//                        channel clip_cnt registers; otherwise clip_led is
//                        tied to 0 and no clip logic exists.
//
// Timing (sample accepted at edge T0):
//   channel c updates at edge T0+1+c, the FSM returns to IDLE and update_done
//   is raised at edge T0+NUM_CH. A strobe seen while the FSM is still in SWEEP
//   (including the edge of the last channel update) is dropped and sets
//   overrun.
// ----------------------------------------------------------------------------
module level_meter #(
    parameter int NUM_CH       = 8,
    parameter int HOLD_SAMPLES = 24000,
    parameter int DECAY_SHIFT  = 10,
    parameter int CLIP_HOLD    = 48000
) (
    input  logic         clk,
    input  logic         rst_n,
    level_meter_if.slave bus
);

    localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int HOLD_W   = $clog2(HOLD_SAMPLES + 1);
    localparam int LED_N    = 8;
    // Segment k lights at 2^(LED_BASE+k); the top segment sits at -6 dBFS.
    localparam int LED_BASE = 15;

    typedef enum logic {
        S_IDLE,
        S_SWEEP
    } state_e;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_e                 state_q, state_d;
    logic [CH_W-1:0]        ch_q, ch_d;
    logic [24*NUM_CH-1:0]   shadow_q, shadow_d;
    logic [22:0]            peak_q [NUM_CH];
    logic [22:0]            peak_d [NUM_CH];
    logic [HOLD_W-1:0]      hold_q [NUM_CH];
    logic [HOLD_W-1:0]      hold_d [NUM_CH];
    logic [LED_N-1:0]       led_q, led_d;
    logic                   overrun_q, overrun_d;
    logic                   done_q, done_d;

    // Channel currently being processed and its magnitude.
    logic [23:0]            cur_sample;
    logic [22:0]            cur_mag;
    logic                   cur_active;
    logic [22:0]            peak_sel;

    // Decay step: peak >> DECAY_SHIFT, but never less than 1 so small peaks
    // still reach zero.
    function automatic logic [22:0] decay_step(input logic [22:0] p);
        logic [22:0] step;
        step = p >> DECAY_SHIFT;
        if (step == '0) begin
            step = 23'd1;
        end
        return step;
    endfunction

    // ------------------------------------------------------------------------
    // Sweep FSM
    // ------------------------------------------------------------------------
    // NOTE: every combinational output gets a default before any branch, so
    // no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        shadow_d  = shadow_q;
        overrun_d = overrun_q;
        done_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.sample_valid) begin
                    shadow_d = bus.audio_bus;
                    ch_d     = '0;
                    state_d  = S_SWEEP;
                end
            end

            S_SWEEP: begin
                // A strobe during the sweep is dropped; the shadow copy
                // stays intact so the running sweep is not corrupted.
                if (bus.sample_valid) begin
                    overrun_d = 1'b1;
                end
                if (ch_q == CH_W'(NUM_CH - 1)) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    ch_d = ch_q + CH_W'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign cur_active = (state_q == S_SWEEP);

    // ------------------------------------------------------------------------
    // Current channel sample and magnitude
    // ------------------------------------------------------------------------
    always_comb begin
        cur_sample = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_q == CH_W'(i)) begin
                cur_sample = shadow_q[24*i +: 24];
            end
        end
    end

    // |x| in 23 bits. For negative x the low 23 bits of the two's complement
    // negation are exact except for -2^23, whose magnitude does not fit and
    // is saturated to full scale.
    always_comb begin
        if (!cur_sample[23]) begin
            cur_mag = cur_sample[22:0];
        end else if (cur_sample[22:0] == '0) begin
            cur_mag = '1;
        end else begin
            cur_mag = ~cur_sample[22:0] + 23'd1;
        end
    end

    // ------------------------------------------------------------------------
    // Peak hold / decay envelope
    // ------------------------------------------------------------------------
    always_comb begin
        peak_d = peak_q;
        hold_d = hold_q;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cur_active && (ch_q == CH_W'(i))) begin
                if (cur_mag >= peak_q[i]) begin
                    peak_d[i] = cur_mag;
                    hold_d[i] = HOLD_W'(HOLD_SAMPLES);
                end else if (hold_q[i] != '0) begin
                    hold_d[i] = hold_q[i] - HOLD_W'(1);
                end else if (peak_q[i] != '0) begin
                    peak_d[i] = (peak_q[i] > decay_step(peak_q[i]))
                              ? peak_q[i] - decay_step(peak_q[i])
                              : '0;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Bargraph of the selected channel
    // ------------------------------------------------------------------------
    always_comb begin
        peak_sel = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (bus.sel == 3'(i)) begin
                peak_sel = peak_q[i];
            end
        end
        led_d = '0;
        for (int k = 0; k < LED_N; k++) begin
            led_d[k] = (peak_sel >= (23'd1 << (LED_BASE + k)));
        end
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge value of every other flop.
    // NOTE: the per-channel envelopes are flop arrays, not RAM, and are all
    // cleared by reset; a reset mid-sweep therefore leaves no partial state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            ch_q      <= '0;
            shadow_q  <= '0;
            led_q     <= '0;
            overrun_q <= 1'b0;
            done_q    <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                peak_q[i] <= '0;
                hold_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            ch_q      <= ch_d;
            shadow_q  <= shadow_d;
            led_q     <= led_d;
            overrun_q <= overrun_d;
            done_q    <= done_d;
            peak_q    <= peak_d;
            hold_q    <= hold_d;
        end
    end

    // ------------------------------------------------------------------------
    // Clip detection (optional)
    // ------------------------------------------------------------------------
`ifdef LEVEL_METER_CLIP_EN
    localparam int CLIP_W = $clog2(CLIP_HOLD + 1);

    logic [CLIP_W-1:0] clip_cnt_q [NUM_CH];
    logic [CLIP_W-1:0] clip_cnt_d [NUM_CH];
    logic              clip_led_q, clip_led_d;
    logic              cur_clip;

    // Full-scale codes only occur when the upstream saturator engaged.
    assign cur_clip = (cur_sample == 24'h7F_FFFF) || (cur_sample == 24'h80_0000);

    always_comb begin
        clip_cnt_d = clip_cnt_q;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cur_active && (ch_q == CH_W'(i))) begin
                if (cur_clip) begin
                    clip_cnt_d[i] = CLIP_W'(CLIP_HOLD);
                end else if (clip_cnt_q[i] != '0) begin
                    clip_cnt_d[i] = clip_cnt_q[i] - CLIP_W'(1);
                end
            end
        end
    end

    always_comb begin
        clip_led_d = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (bus.sel == 3'(i)) begin
                clip_led_d = (clip_cnt_q[i] != '0);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clip_led_q <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                clip_cnt_q[i] <= '0;
            end
        end else begin
            clip_led_q <= clip_led_d;
            clip_cnt_q <= clip_cnt_d;
        end
    end

    assign bus.clip_led = clip_led_q;
`else
    assign bus.clip_led = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.led         = led_q;
    assign bus.busy        = (state_q == S_SWEEP);
    assign bus.overrun     = overrun_q;
    assign bus.update_done = done_q;

endmodule

// File: tb/tb_level_meter.sv
// ----------------------------------------------------------------------------
// tb_level_meter
//
// Directed testbench for level_meter. The hold and clip-hold lengths are
// shortened (HOLD, CLIP below) so the hold/decay and clip-expiry boundaries
// are reached in a few hundred strobes; the boundary arithmetic is the same
// as with the production values. Internal peak registers are observed via
// hierarchical references since peak is not a port.
// ----------------------------------------------------------------------------
module tb_level_meter;

    localparam int NUM_CH = 8;
    localparam int HOLD   = 40;
    localparam int CLIP   = 60;
    localparam int W      = 24 * NUM_CH;

`ifdef LEVEL_METER_CLIP_EN
    localparam logic [31:0] CLIP_ON = 32'd1;
`else
    localparam logic [31:0] CLIP_ON = 32'd0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    level_meter_if #(.NUM_CH(NUM_CH)) lm_if ();

    level_meter #(
        .NUM_CH       (NUM_CH),
        .HOLD_SAMPLES (HOLD),
        .DECAY_SHIFT  (10),
        .CLIP_HOLD    (CLIP)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (lm_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] one_ch(input int c, input logic [23:0] v);
        logic [W-1:0] b;
        b = '0;
        b[c*24 +: 24] = v;
        return b;
    endfunction

    // Advance n rising edges, then settle 1 time unit past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present one strobe; returns just after the capturing edge T0.
    task automatic strobe(input logic [W-1:0] b);
        lm_if.sample_valid = 1'b1;
        lm_if.audio_bus    = b;
        tick(1);
        lm_if.sample_valid = 1'b0;
        lm_if.audio_bus    = '0;
    endtask

    // Strobe and wait for the sweep to finish (returns just after T0+NUM_CH).
    task automatic sweep(input logic [W-1:0] b);
        strobe(b);
        tick(NUM_CH);
    endtask

    task automatic sweep_zeros(input int n);
        for (int i = 0; i < n; i++) begin
            sweep('0);
        end
    endtask

    task automatic do_reset();
        lm_if.sample_valid = 1'b0;
        lm_if.audio_bus    = '0;
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
    endtask

    function automatic logic [31:0] outs();
        return {27'd0, lm_if.led[7:4] != 4'd0 ? 1'b1 : 1'b0, lm_if.led[3:0] != 4'd0 ? 1'b1 : 1'b0,
                lm_if.clip_led, lm_if.busy, lm_if.overrun} | {lm_if.update_done, 31'd0};
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        lm_if.sample_valid = 1'b0;
        lm_if.audio_bus    = '0;
        lm_if.sel          = 3'd0;
        do_reset();

        // ---------------- reset values ----------------
        check("reset_outputs", outs(), 32'd0);

        // ---------------- peak capture, timing, hold, decay ----------------
        lm_if.sel = 3'd0;
        strobe(one_ch(0, 24'h40_0000));
        check("busy_after_t0", 32'(lm_if.busy), 32'd1);
        check("peak0_before_update", 32'(dut.peak_q[0]), 32'd0);
        tick(1);
        check("peak0_at_t0p1", 32'(dut.peak_q[0]), 32'h40_0000);
        check("led_lags_update", 32'(lm_if.led), 32'h00);
        tick(1);
        check("led_full", 32'(lm_if.led), 32'hFF);
        tick(NUM_CH - 2);
        check("update_done_pulse", 32'(lm_if.update_done), 32'd1);
        check("busy_done", 32'(lm_if.busy), 32'd0);
        tick(1);
        check("update_done_clears", 32'(lm_if.update_done), 32'd0);
        sweep_zeros(HOLD);
        check("peak0_held", 32'(dut.peak_q[0]), 32'h40_0000);
        sweep_zeros(1);
        check("peak0_first_decay", 32'(dut.peak_q[0]), 32'h3F_F000);
        tick(1);
        check("led_below_top", 32'(lm_if.led), 32'h7F);

        // ---------------- decay floor ----------------
        do_reset();
        sweep(one_ch(1, 24'd5));
        sweep_zeros(HOLD);
        check("peak1_held_5", 32'(dut.peak_q[1]), 32'd5);
        for (int k = 1; k <= 6; k++) begin
            sweep_zeros(1);
            check($sformatf("decay_floor_%0d", k), 32'(dut.peak_q[1]), (k < 5) ? 32'(5 - k) : 32'd0);
        end

        // ---------------- negative full scale and clip ----------------
        do_reset();
        lm_if.sel = 3'd3;
        sweep(one_ch(3, 24'h80_0000));
        tick(1);
        check("negfs_peak3", 32'(dut.peak_q[3]), 32'h7F_FFFF);
        check("negfs_led", 32'(lm_if.led), 32'hFF);
        check("negfs_clip_on", 32'(lm_if.clip_led), CLIP_ON);
        sweep_zeros(CLIP - 1);
        tick(1);
        check("clip_last_lit", 32'(lm_if.clip_led), CLIP_ON);
        sweep_zeros(1);
        tick(1);
        check("clip_expired", 32'(lm_if.clip_led), 32'd0);

        // Positive full scale clips, one code below does not; magnitude of a
        // non-full-scale negative sample.
        do_reset();
        sweep(one_ch(4, 24'h7F_FFFF) | one_ch(2, 24'h7F_FFFE) | one_ch(6, 24'hF0_0000));
        lm_if.sel = 3'd4;
        tick(2);
        check("posfs_clip", 32'(lm_if.clip_led), CLIP_ON);
        lm_if.sel = 3'd2;
        tick(2);
        check("near_fs_no_clip", 32'(lm_if.clip_led), 32'd0);
        check("near_fs_peak2", 32'(dut.peak_q[2]), 32'h7F_FFFE);
        lm_if.sel = 3'd6;
        tick(2);
        check("neg_mag_peak6", 32'(dut.peak_q[6]), 32'h10_0000);
        check("neg_mag_led", 32'(lm_if.led), 32'h3F);

        // ---------------- overrun ----------------
        do_reset();
        sweep(one_ch(1, 24'h10_0000));
        sweep(one_ch(2, 24'h20_0000));     // 9 cycles after the first
        tick(1);
        check("spacing9_no_overrun", 32'(lm_if.overrun), 32'd0);
        check("spacing9_peak2", 32'(dut.peak_q[2]), 32'h20_0000);

        strobe(one_ch(4, 24'h30_0000));
        tick(NUM_CH - 1);
        strobe(one_ch(5, 24'h30_0000));    // lands on the last-channel edge
        tick(NUM_CH + 1);
        check("completion_edge_overrun", 32'(lm_if.overrun), 32'd1);
        check("completion_edge_peak5", 32'(dut.peak_q[5]), 32'd0);
        check("completion_edge_peak4", 32'(dut.peak_q[4]), 32'h30_0000);

        do_reset();
        check("overrun_cleared_by_reset", 32'(lm_if.overrun), 32'd0);
        strobe(one_ch(1, 24'h10_0000));
        tick(3);
        strobe(one_ch(6, 24'h20_0000));    // 4 cycles after the first
        tick(NUM_CH);
        check("spacing4_overrun", 32'(lm_if.overrun), 32'd1);
        check("spacing4_peak6", 32'(dut.peak_q[6]), 32'd0);
        check("spacing4_peak1", 32'(dut.peak_q[1]), 32'h10_0000);

        // ---------------- sel switching ----------------
        do_reset();
        sweep(one_ch(5, 24'h01_0000));
        lm_if.sel = 3'd5;
        tick(2);
        check("sel5_led", 32'(lm_if.led), 32'h03);
        lm_if.sel = 3'd6;
        #1;
        check("sel6_before_edge", 32'(lm_if.led), 32'h03);
        tick(1);
        check("sel6_led", 32'(lm_if.led), 32'h00);

        // ---------------- reset mid-sweep ----------------
        do_reset();
        lm_if.sel = 3'd0;
        strobe(one_ch(0, 24'h40_0000));
        tick(3);                            // just past T0+3
        check("midsweep_led_before", 32'(lm_if.led), 32'hFF);
        rst_n = 1'b0;
        #1;
        check("midsweep_outputs_zero", outs(), 32'd0);
        check("midsweep_peak0_zero", 32'(dut.peak_q[0]), 32'd0);
        tick(1);
        rst_n = 1'b1;
        tick(1);
        sweep('0);
        tick(1);
        check("post_reset_zero_led", 32'(lm_if.led), 32'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/level_meter.md
# level_meter

Per-channel peak level meter for the eight-channel mixer output. It sits downstream of the output saturation stage and consumes the same 24-bit signed sample bus that feeds the ADAT transmitter. On each sample strobe it updates a peak-hold/decay envelope for every channel. It drives an 8-segment LED bargraph for one selectable channel and a latched clip indicator.

## Interface
- `NUM_CH`, 8: number of channels on the audio bus.
- `HOLD_SAMPLES`, 24000: samples a new peak is held before decay starts (0.5 s at 48 kHz).
- `DECAY_SHIFT`, 10: decay step per sample is `peak >> DECAY_SHIFT`, minimum 1.
- `CLIP_HOLD`, 48000: samples the clip indicator stays lit after the last clip.
- `clk`  in  1: DSP clock (the oversampling bitclock domain).
- `rst_n`  in  1: reset, asynchronous, active-low.
- `sample_valid`  in  1: single-cycle strobe; `audio_bus` is valid in this cycle.
- `audio_bus`  in  24×NUM_CH: signed samples, channel 0 first.
- `sel`  in  3: channel shown on `led`.
- `led`  out  8: thermometer bargraph of `peak[sel]`.
- `clip_led`  out  1: clip indicator for channel `sel`.
- `busy`  out  1: sweep in progress.
- `overrun`  out  1: sticky; a strobe arrived while `busy`.
- `update_done`  out  1: one-cycle pulse when a sweep completes.

## Operation
- **Reset values:**
  - All outputs are 0.
  - All `peak`, `hold`, and `clip_cnt` registers are 0.
  - The FSM is in IDLE.
  - Reset asserted mid-sweep aborts the sweep; no partial state survives.
- **FSM states:** IDLE, SWEEP.
  - IDLE → SWEEP on `sample_valid`. That edge captures all of `audio_bus` into a shadow register and sets `ch`=0.
  - SWEEP processes channel `ch` each cycle and increments `ch`.
  - After channel NUM_CH−1, the FSM returns to IDLE and pulses `update_done`.
- **Overrun:** a `sample_valid` while in SWEEP is ignored (the shadow register is unchanged) and sets `overrun`. `overrun` clears only on reset.
- **Magnitude:** `mag = |x|`, 23-bit unsigned. −8388608 saturates to 0x7FFFFF.
- **Per-channel update:** the first matching rule applies.
  - If `mag >= peak`: `peak = mag` and `hold = HOLD_SAMPLES`.
  - Else if `hold != 0`: `hold` decrements.
  - Else if `peak != 0`: `peak` decreases by `max(peak >> DECAY_SHIFT, 1)`, never going below 0.
- **Bargraph:** bit k (0..7) of `led` is 1 iff `peak[sel] >= 2^(15+k)`. Bit 7 means ≥ −6 dBFS, with roughly 6 dB per segment.
- **Clip detection:** a sample with `x == 0x7FFFFF` or `x == 0x800000` (a full-scale, i.e. saturated, output) loads `clip_cnt[ch] = CLIP_HOLD`. Otherwise a nonzero `clip_cnt` decrements once per update.
- **Clip indicator:** `clip_led = (clip_cnt[sel] != 0)`.
- **State storage:** per-channel state is held in registers (NUM_CH × (23 + hold + clip) bits), not RAM.

## Timing
- The sample captured at edge T0 (the `sample_valid` edge) is processed as follows:
  - Channel c updates at edge T0+1+c.
  - `busy` is high from T0+1 through T0+NUM_CH.
  - `update_done` is high for the cycle after edge T0+NUM_CH.
- `led` and `clip_led` are registered from the current `peak[sel]` and `clip_cnt[sel]` every cycle. They reflect a `sel` change or a channel update one cycle later.
- **Minimum strobe spacing:** NUM_CH+1 cycles. Normal ADAT frame spacing is about 2048 cycles, so overrun indicates an upstream fault.
- **Strobe on the completion cycle:** a strobe in the same cycle the last channel updates counts as overrun. A strobe on the cycle after that is accepted.
- **Counter saturation:**
  - `hold` and `clip_cnt` never wrap below 0.
  - `peak` never wraps.

## Configuration
- **`LEVEL_METER_CLIP_EN` defined:** clip detection and `clip_cnt` registers are built as described.
- **`LEVEL_METER_CLIP_EN` not defined:** no clip logic is built and `clip_led` is tied 0. All other behaviour is identical.

## Test plan
- **Reset mid-sweep:** strobe ch0=0x400000, then assert `rst_n`=0 at T0+3.
  - Required: all outputs 0 immediately.
  - Required: a later strobe with all-zero input leaves `led`=0x00.
- **Peak capture and hold:** strobe ch0=0x400000 once, then zeros; `sel`=0.
  - Required: `led`=0xFF two cycles after the ch0 update.
  - Required: `peak[0]` stays 0x400000 for exactly 24000 subsequent zero samples, then becomes 0x3FF000.
- **Negative full scale:** strobe ch3=0x800000, `sel`=3.
  - Required: `peak[3]`=0x7FFFFF and `led`=0xFF.
  - Required: `clip_led`=1 for 48000 strobes, then 0.
  - Required: the same stimulus with `LEVEL_METER_CLIP_EN` undefined gives `clip_led`=0 throughout.
- **Decay floor:** preload `peak`=5 with hold expired, then feed zero samples.
  - Required: `peak` decreases by 1 per strobe and stays at 0.
- **Overrun:**
  - Strobes 4 cycles apart → `overrun`=1, and the second sample does not affect any peak.
  - Strobes 9 cycles apart → accepted, `overrun` stays 0.
- **`sel` switching:** ch5 peak=0x010000 and ch6 peak=0; switch `sel` 5→6.
  - Required: `led` goes 0x03→0x00 one cycle after the change.
